wb_daq_slave_regfile: RTL and testbench
=======================================

# wb_daq_slave_regfile

Parametrised Wishbone B3 classic slave register bank for the DAQ subsystem, the successor to the single-register DAQ slave. It provides `NUM_REGS` byte-maskable read/write registers exported to the datapath and a maskable, edge-triggered interrupt controller with write-1-to-clear status. It returns `wb_err_o` for unmapped addresses. It sits on the DAQ Wishbone bus beside the DSP/acquisition cores.

## Interface
Clock is `wb_clk`; reset is `wb_rst`, synchronous and active-high.

Parameters:
- `dw`, 32: data width; must be a multiple of 8.
- `aw`, 8: byte-address width.
- `NUM_REGS`, 8: number of general R/W registers, 1..(2^(aw-2))-3.
- `NUM_IRQ`, 8: interrupt sources, 1..dw.
- `VERSION`, 32'h0002_0000: value of the read-only version register.

Ports:
- `wb_clk` in 1: clock.
- `wb_rst` in 1: synchronous active-high reset.
- `wb_adr_i` in aw: byte address; word index = `wb_adr_i[aw-1:2]`, bits [1:0] ignored.
- `wb_dat_i` in dw: write data.
- `wb_sel_i` in dw/8: byte enables.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i` in 1 each: standard Wishbone controls.
- `wb_cti_i` in 3, `wb_bte_i` in 2: accepted and ignored; every access is classic.
- `wb_dat_o` out dw: registered read data.
- `wb_ack_o`, `wb_err_o`, `wb_rty_o` out 1 each: termination signals; `wb_rty_o` is tied to 0.
- `slave_reg` out NUM_REGS*dw: flattened registers; register k is `[k*dw +: dw]`.
- `irq_src_i` in NUM_IRQ: interrupt sources (synchronous to `wb_clk`).
- `interrupt` out 1: registered, level, active-high.

## Operation
Word map:
- Index 0..NUM_REGS-1: REG[k], R/W.
- Index NUM_REGS: IRQ_STATUS, read / write-1-to-clear.
- Index NUM_REGS+1: IRQ_ENABLE, R/W.
- Index NUM_REGS+2: VERSION, read-only; writes are ignored but still acked.
- Any other index terminates with `wb_err_o`; no state changes and `wb_dat_o` is unchanged.

Register behaviour:
- A request is `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`. The slave accepts exactly one access per request.
- Writes apply per byte lane under `wb_sel_i`. IRQ_STATUS clears only bits that are 1 in an enabled lane.
- Bits at position NUM_IRQ and above in IRQ_STATUS and IRQ_ENABLE read as 0 and are not writable.
- Edge detection: `irq_src_d` is the previous-cycle copy of `irq_src_i`. A rising edge (`irq_src_i & ~irq_src_d`) sets the corresponding IRQ_STATUS bit regardless of IRQ_ENABLE.
- `interrupt` is registered from `|(IRQ_STATUS & IRQ_ENABLE)`.

## Timing
Reset values:
- `wb_ack_o`, `wb_err_o`, `wb_rty_o`, `wb_dat_o`, `interrupt`: 0.
- All REG[k], IRQ_STATUS, IRQ_ENABLE and `irq_src_d`: 0.
- A source already high when reset releases therefore registers as an edge in the first cycle after reset.

Access timing:
- A request sampled at edge N produces `wb_ack_o` or `wb_err_o` high for exactly cycle N+1.
- Read data is valid in that same cycle and holds until the next read.
- Write data commits at edge N and is visible on `slave_reg` from cycle N+1.
- A master holding `stb` for back-to-back accesses is terminated every other cycle.
- Reset asserted mid-access drops `ack`/`err` on the next edge; the access is lost and the write is discarded only if reset and request coincide.

Interrupt timing:
- Source edge at edge N sets IRQ_STATUS at N; `interrupt` is high from N+1 if enabled.
- Enabling a pending bit at edge N raises `interrupt` at N+1.
- A clear at N drops `interrupt` at N+1 if no other pending-enabled bit remains.

Boundary cases:
- A simultaneous hardware set and W1C on the same bit: set wins and the bit stays 1.
- A read of IRQ_STATUS at edge N returns the pre-update value, excluding a set occurring at N.

## Structure
- Package `wb_daq_pkg` holds the offset constants (`IRQ_STATUS_OFS`, `IRQ_ENABLE_OFS`, `VERSION_OFS` as functions of NUM_REGS) and the default VERSION value.
- Sub-module `wb_daq_irq_ctrl` contains the edge detector, status and enable registers, and the `interrupt` flop. It takes write strobes, byte masks and data from the bus decode and returns status and enable for readback.
- The top level contains the bus handshake, address decode, REG array and read mux. It is roughly 250 lines total.

## Test plan
Defaults: dw=32, NUM_REGS=8, NUM_IRQ=8.
- Reset, then read every index 0..10: REG/IRQ read 0, index 10 reads 32'h0002_0000, each access is acked exactly once one cycle later, and index 11 gets `wb_err_o` with no ack.
- Write 32'hDEADBEEF to REG[3] with sel=4'hF, then 32'h11223344 with sel=4'b0101: REG[3] = 32'hDE22BE44 and `slave_reg[127:96]` matches from the cycle after each ack.
- Pulse `irq_src_i[2]` with IRQ_ENABLE=0: STATUS=32'h4 and `interrupt`=0. Write ENABLE=32'h4: `interrupt`=1 one cycle later. W1C 32'h4: `interrupt`=0 one cycle later.
- Hold `irq_src_i[5]` high for 10 cycles, clearing STATUS mid-way: the bit is not re-set (no new edge). Issue a W1C in the same cycle as a new edge on bit 1: bit 1 remains 1.
- Hold `stb` high over 4 consecutive reads: `ack` toggles 1,0,1,0 and each datum matches its address. Write to VERSION: acked, value unchanged.
- Assert `wb_rst` during a pending interrupt and after a write: all outputs and registers return to 0 on the next edge.

Source files
------------

// File: rtl/wb_daq_pkg.sv
// rtl/wb_daq_pkg.sv - word map offsets and defaults for the DAQ Wishbone register bank
package wb_daq_pkg;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

  // Control words sit directly above the general register block
  function automatic int IRQ_STATUS_OFS(input int num_regs);
    return num_regs;
  endfunction

  function automatic int IRQ_ENABLE_OFS(input int num_regs);
    return num_regs + 1;
  endfunction

  function automatic int VERSION_OFS(input int num_regs);
    return num_regs + 2;
  endfunction

endpackage

// File: rtl/wb_daq_irq_ctrl.sv
// rtl/wb_daq_irq_ctrl.sv - edge-triggered interrupt status/enable with write-1-to-clear
module wb_daq_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               status_w1c,
  input  logic               enable_we,
  input  logic [NUM_IRQ-1:0] wr_data,
  input  logic [NUM_IRQ-1:0] wr_mask,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic [NUM_IRQ-1:0] irq_enable,
  output logic               interrupt
);

  logic [NUM_IRQ-1:0] irq_src_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = irq_src_i & ~irq_src_d;
  assign clr  = status_w1c ? (wr_data & wr_mask) : '0;

  // Edge capture, W1C status (a same-cycle set wins), enable write and level output
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      irq_src_d  <= '0;
      irq_status <= '0;
      irq_enable <= '0;
      interrupt  <= 1'b0;
    end else begin
      irq_src_d  <= irq_src_i;
      irq_status <= (irq_status & ~clr) | rise;
      if (enable_we)
        irq_enable <= (irq_enable & ~wr_mask) | (wr_data & wr_mask);
      interrupt  <= |(irq_status & irq_enable);
    end
  end

endmodule

// File: rtl/wb_daq_slave_regfile.sv
// rtl/wb_daq_slave_regfile.sv - Wishbone classic slave register bank with interrupt controller
module wb_daq_slave_regfile
  import wb_daq_pkg::*;
#(
  parameter int          dw       = 32,
  parameter int          aw       = 8,
  parameter int          NUM_REGS = 8,
  parameter int          NUM_IRQ  = 8,
  parameter logic [31:0] VERSION  = VERSION_DEFAULT
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [aw-1:0]          wb_adr_i,
  input  logic [dw-1:0]          wb_dat_i,
  input  logic [dw/8-1:0]        wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [2:0]             wb_cti_i,
  input  logic [1:0]             wb_bte_i,
  output logic [dw-1:0]          wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic [NUM_REGS*dw-1:0] slave_reg,
  input  logic [NUM_IRQ-1:0]     irq_src_i,
  output logic                   interrupt
);

  localparam logic [31:0] NREG_W = NUM_REGS;
  localparam logic [31:0] STAT_W = IRQ_STATUS_OFS(NUM_REGS);
  localparam logic [31:0] ENAB_W = IRQ_ENABLE_OFS(NUM_REGS);
  localparam logic [31:0] VERS_W = VERSION_OFS(NUM_REGS);

  logic [dw-1:0]      regs [NUM_REGS];
  logic [31:0]        idx;
  logic               req, wr, mapped, hit_stat, hit_enab;
  logic [dw-1:0]      byte_mask;
  logic [dw-1:0]      rd_data;
  logic [NUM_IRQ-1:0] irq_status, irq_enable;
  logic               unused_bus_bits;

  // Burst hints and byte offset are irrelevant: every access is a classic word access
  assign unused_bus_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

  assign idx      = 32'(wb_adr_i[aw-1:2]);
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr       = req & wb_we_i;
  assign mapped   = (idx <= VERS_W);
  assign hit_stat = (idx == STAT_W);
  assign hit_enab = (idx == ENAB_W);
  assign wb_rty_o = 1'b0;

  // Expand byte enables into a bit mask shared by all writable words
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < dw / 8; b++)
      byte_mask[b*8 +: 8] = {8{wb_sel_i[b]}};
  end

  // Read mux over the word map; unmapped indices never reach wb_dat_o
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (idx == k) rd_data = regs[k];
    if (hit_stat)      rd_data = dw'(irq_status);
    if (hit_enab)      rd_data = dw'(irq_enable);
    if (idx == VERS_W) rd_data = dw'(VERSION);
  end

  // Bus handshake, registered read data and byte-lane writes to the general registers
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      if (req && mapped && !wb_we_i) wb_dat_o <= rd_data;
      for (int k = 0; k < NUM_REGS; k++)
        if (wr && idx < NREG_W && idx == k)
          regs[k] <= (regs[k] & ~byte_mask) | (wb_dat_i & byte_mask);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign slave_reg[g*dw +: dw] = regs[g];
  end

  wb_daq_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .irq_src_i  (irq_src_i),
    .status_w1c (wr & hit_stat),
    .enable_we  (wr & hit_enab),
    .wr_data    (wb_dat_i[NUM_IRQ-1:0]),
    .wr_mask    (byte_mask[NUM_IRQ-1:0]),
    .irq_status (irq_status),
    .irq_enable (irq_enable),
    .interrupt  (interrupt)
  );

endmodule

// File: tb/tb_wb_daq_slave_regfile.sv
// tb/tb_wb_daq_slave_regfile.sv - directed self-checking bench for wb_daq_slave_regfile
module tb_wb_daq_slave_regfile;

  logic         wb_clk;
  logic         wb_rst;
  logic [7:0]   wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic         wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]   wb_cti_i;
  logic [1:0]   wb_bte_i;
  logic [31:0]  wb_dat_o;
  logic         wb_ack_o, wb_err_o, wb_rty_o;
  logic [255:0] slave_reg;
  logic [7:0]   irq_src_i;
  logic         interrupt;

  int n_vec = 0;
  int n_bad = 0;

  logic         t_ack, t_err, t_ack2;
  logic [31:0]  t_rd;
  logic [255:0] sr_at_ack;
  logic [31:0]  exp_regs [4];
  int           a;

  wb_daq_slave_regfile dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cti_i  (wb_cti_i),
    .wb_bte_i  (wb_bte_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .slave_reg (slave_reg),
    .irq_src_i (irq_src_i),
    .interrupt (interrupt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; request sampled at the next edge, results sampled #1 later
  task automatic xfer(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic ack, output logic err,
                      output logic [31:0] rd, output logic ack2);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; sr_at_ack = slave_reg;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    ack2 = wb_ack_o | wb_err_o;
  endtask

  initial begin
    wb_rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_cti_i = '0; wb_bte_i = '0; irq_src_i = '0;
    repeat (3) @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_err", 32'(wb_err_o), 32'h0);
    chk("rst_rty", 32'(wb_rty_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_int", 32'(interrupt), 32'h0);
    chk("rst_regs", 32'(|slave_reg), 32'h0);

    // Reset read-back sweep over the whole map
    for (int i = 0; i <= 10; i++) begin
      xfer(8'(i * 4), 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
      chk($sformatf("sweep_ack_%0d", i), 32'(t_ack), 32'h1);
      chk($sformatf("sweep_err_%0d", i), 32'(t_err), 32'h0);
      chk($sformatf("sweep_once_%0d", i), 32'(t_ack2), 32'h0);
      chk($sformatf("sweep_dat_%0d", i), t_rd, (i == 10) ? 32'h0002_0000 : 32'h0);
    end
    xfer(8'h2C, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("unmapped_ack", 32'(t_ack), 32'h0);
    chk("unmapped_err", 32'(t_err), 32'h1);
    chk("unmapped_dat_hold", t_rd, 32'h0002_0000);
    chk("unmapped_once", 32'(t_ack2), 32'h0);

    // Byte-lane writes to REG[3]
    xfer(8'h0C, 1'b1, 32'hDEADBEEF, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("reg3_full_ack", 32'(t_ack), 32'h1);
    chk("reg3_full", sr_at_ack[127:96], 32'hDEADBEEF);
    xfer(8'h0C, 1'b1, 32'h11223344, 4'b0101, t_ack, t_err, t_rd, t_ack2);
    chk("reg3_lanes", sr_at_ack[127:96], 32'hDE22BE44);
    xfer(8'h0C, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("reg3_read", t_rd, 32'hDE22BE44);

    // Pulse source 2 while disabled, then enable and clear
    irq_src_i[2] = 1'b1;
    @(posedge wb_clk); #1;
    irq_src_i[2] = 1'b0;
    @(posedge wb_clk); #1;
    xfer(8'h20, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("stat_pulse2", t_rd, 32'h4);
    chk("int_disabled", 32'(interrupt), 32'h0);
    xfer(8'h24, 1'b1, 32'h4, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("int_enabled", 32'(interrupt), 32'h1);
    xfer(8'h20, 1'b1, 32'h4, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("int_cleared", 32'(interrupt), 32'h0);

    // Held source 5: clear while still high must not re-set
    irq_src_i[5] = 1'b1;
    @(posedge wb_clk); #1;
    xfer(8'h20, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("stat_held5", t_rd, 32'h20);
    xfer(8'h20, 1'b1, 32'h20, 4'hF, t_ack, t_err, t_rd, t_ack2);
    repeat (3) @(posedge wb_clk);
    #1;
    xfer(8'h20, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("stat_no_reset5", t_rd, 32'h0);
    irq_src_i[5] = 1'b0;

    // W1C coinciding with a fresh edge on bit 1: set wins
    irq_src_i[1] = 1'b1;
    xfer(8'h20, 1'b1, 32'h2, 4'hF, t_ack, t_err, t_rd, t_ack2);
    irq_src_i[1] = 1'b0;
    xfer(8'h20, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("set_beats_clr", t_rd, 32'h2);

    // Back-to-back reads with stb held
    exp_regs[0] = 32'hA0A0_0001;
    exp_regs[1] = 32'hA1A1_0002;
    exp_regs[2] = 32'hA2A2_0003;
    exp_regs[3] = 32'hDE22BE44;
    for (int i = 0; i < 3; i++)
      xfer(8'(i * 4), 1'b1, exp_regs[i], 4'hF, t_ack, t_err, t_rd, t_ack2);
    a = 0;
    wb_adr_i = 8'h00; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk); #1;
      chk($sformatf("b2b_ack_%0d", i), 32'(wb_ack_o), (i % 2 == 0) ? 32'h1 : 32'h0);
      if (wb_ack_o && a < 4) begin
        chk($sformatf("b2b_dat_%0d", a), wb_dat_o, exp_regs[a]);
        a++;
        wb_adr_i = 8'(a * 4);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("b2b_count", 32'(a), 32'h4);

    // VERSION is read-only but still acked
    @(posedge wb_clk); #1;
    xfer(8'h28, 1'b1, 32'hFFFFFFFF, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("ver_wr_ack", 32'(t_ack), 32'h1);
    xfer(8'h28, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("ver_unchanged", t_rd, 32'h0002_0000);

    // Reset with a pending interrupt and fresh register contents
    xfer(8'h24, 1'b1, 32'h2, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("int_pending", 32'(interrupt), 32'h1);
    xfer(8'h14, 1'b1, 32'h12345678, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("reg5_write", sr_at_ack[191:160], 32'h12345678);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    chk("rst2_int", 32'(interrupt), 32'h0);
    chk("rst2_regs", 32'(|slave_reg), 32'h0);
    chk("rst2_dat", wb_dat_o, 32'h0);
    chk("rst2_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
    wb_rst = 1'b0;
    xfer(8'h20, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("rst2_stat", t_rd, 32'h0);
    xfer(8'h24, 1'b0, 32'h0, 4'hF, t_ack, t_err, t_rd, t_ack2);
    chk("rst2_enab", t_rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
